// File: rtl/serial2tcp_loopback.sv
// serial2tcp_loopback: echoes every byte accepted on the source stream back
// out on the sink stream through a first-word-fall-through byte FIFO.
// Optional build macro SERIAL2TCP_LOOPBACK_CRLF_EN: every 0x0D leaving the
// FIFO is followed by an inserted 0x0A. The inserted byte never occupies a
// FIFO entry.
module serial2tcp_loopback #(
    parameter int DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       serial2tcp_source_valid,
    output logic       serial2tcp_source_ready,
    input  logic [7:0] serial2tcp_source_data,
    output logic       serial2tcp_sink_valid,
    input  logic       serial2tcp_sink_ready,
    output logic [7:0] serial2tcp_sink_data
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          run;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;

    // Ready comes only from registered state, so it never follows sink_ready
    // combinationally; a full FIFO refuses pushes even while it is popped.
    assign fifo_nonempty           = (count != '0);
    assign serial2tcp_source_ready = run && (count < FULL_CNT);
    assign push                    = serial2tcp_source_valid && serial2tcp_source_ready;

`ifdef SERIAL2TCP_LOOPBACK_CRLF_EN
    typedef enum logic {
        PASS      = 1'b0,
        INSERT_LF = 1'b1
    } lf_state_t;

    lf_state_t state;
    lf_state_t state_nxt;

    // Output FSM state register; reset drops any pending inserted LF.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    // Output selection: FIFO head in PASS, a synthesized LF in INSERT_LF.
    always_comb begin
        state_nxt             = state;
        pop                   = 1'b0;
        serial2tcp_sink_valid = 1'b0;
        serial2tcp_sink_data  = 8'h00;
        case (state)
            PASS: begin
                serial2tcp_sink_valid = fifo_nonempty;
                if (fifo_nonempty) begin
                    serial2tcp_sink_data = mem[rd_ptr];
                end
                pop = fifo_nonempty && serial2tcp_sink_ready;
                if (pop && (mem[rd_ptr] == 8'h0D)) begin
                    state_nxt = INSERT_LF;
                end
            end
            INSERT_LF: begin
                serial2tcp_sink_valid = 1'b1;
                serial2tcp_sink_data  = 8'h0A;
                if (serial2tcp_sink_ready) begin
                    state_nxt = PASS;
                end
            end
            default: state_nxt = PASS;
        endcase
    end
`else
    // Plain pass-through: the FIFO head is the sink byte, zero when empty.
    always_comb begin
        serial2tcp_sink_valid = fifo_nonempty;
        serial2tcp_sink_data  = 8'h00;
        if (fifo_nonempty) begin
            serial2tcp_sink_data = mem[rd_ptr];
        end
        pop = fifo_nonempty && serial2tcp_sink_ready;
    end
`endif

    // FIFO control: pointers wrap modulo DEPTH, occupancy spans 0..DEPTH.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            run <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the cleared pointers make old contents unreachable.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= serial2tcp_source_data;
        end
    end

endmodule

// File: tb/tb_serial2tcp_loopback.sv
// tb_serial2tcp_loopback: randomized and directed stimulus for the
// serial2tcp_loopback echo FIFO, checked against a queue-based model and an
// output-stream scoreboard.
module tb_serial2tcp_loopback;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       src_valid;
    logic       src_ready;
    logic [7:0] src_data;
    logic       snk_valid;
    logic       snk_ready;
    logic [7:0] snk_data;
    logic       tog;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: bytes held in the FIFO, a pending inserted LF, and
    // whether the block has left reset. exp_q is the expected output stream.
    logic [7:0] model_fifo [$];
    logic [7:0] exp_q [$];
    bit         lf_pend = 1'b0;
    bit         run     = 1'b0;
    bit         live    = 1'b0;

    serial2tcp_loopback #(.DEPTH(DEPTH)) dut (
        .sys_clk                 (clk),
        .sys_rst_n               (rst_n),
        .serial2tcp_source_valid (src_valid),
        .serial2tcp_source_ready (src_ready),
        .serial2tcp_source_data  (src_data),
        .serial2tcp_sink_valid   (snk_valid),
        .serial2tcp_sink_ready   (snk_ready),
        .serial2tcp_sink_data    (snk_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and model: compare the DUT against the model state reached at
    // the last rising edge, then advance the model with the inputs that the
    // next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (live) begin
                logic       e_rdy;
                logic       e_vld;
                logic [7:0] e_dat;
                e_rdy = run && (model_fifo.size() < DEPTH);
                e_vld = lf_pend || (model_fifo.size() > 0);
                e_dat = lf_pend ? 8'h0A : ((model_fifo.size() > 0) ? model_fifo[0] : 8'h00);
                check("source_ready", src_ready, e_rdy);
                check("sink_valid", snk_valid, e_vld);
                check("sink_data", snk_data, e_dat);
                if (rst_n && snk_valid && snk_ready) begin
                    check("sb_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("sb_data", snk_data, exp_q.pop_front());
                    end
                end
            end
            if (!rst_n) begin
                model_fifo.delete();
                exp_q.delete();
                lf_pend = 1'b0;
                run     = 1'b0;
                live    = 1'b1;
            end else if (live) begin
                bit acc;
                bit pop;
                acc = src_valid && run && (model_fifo.size() < DEPTH);
                pop = snk_ready && (lf_pend || (model_fifo.size() > 0));
                if (pop) begin
                    if (lf_pend) begin
                        lf_pend = 1'b0;
                    end else begin
                        logic [7:0] b;
                        b = model_fifo.pop_front();
`ifdef SERIAL2TCP_LOOPBACK_CRLF_EN
                        if (b == 8'h0D) lf_pend = 1'b1;
`endif
                    end
                end
                if (acc) begin
                    model_fifo.push_back(src_data);
                    exp_q.push_back(src_data);
`ifdef SERIAL2TCP_LOOPBACK_CRLF_EN
                    if (src_data == 8'h0D) exp_q.push_back(8'h0A);
`endif
                end
                run = 1'b1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte and hold it until accepted; valid is left asserted so
    // back-to-back calls form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        src_valid = 1'b1;
        src_data  = b;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = src_ready;
            @(posedge clk);
            #1;
            if (tog) snk_ready = ~snk_ready;
            n++;
        end
        check("send_accept", acc, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        snk_ready = 1'b0;
        tog       = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Simple echo
        snk_ready = 1'b1;
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        src_valid = 1'b0;
        idle(5);

        // Fill to DEPTH, refuse the extra offer, then drain
        snk_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i));
        src_valid = 1'b1;
        src_data  = 8'h10;
        idle(3);
        src_valid = 1'b0;
        snk_ready = 1'b1;
        idle(DEPTH + 8);

        // 256-byte stream with sink_ready toggling every cycle
        snk_ready = 1'b0;
        tog       = 1'b1;
        for (int i = 0; i < 256; i++) send_byte(8'(i));
        src_valid = 1'b0;
        tog       = 1'b0;
        snk_ready = 1'b1;
        idle(DEPTH + 8);

        // Reset with bytes queued; 0x55 must be the first byte afterwards
        snk_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i));
        src_valid = 1'b0;
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        snk_ready = 1'b1;
        send_byte(8'h55);
        src_valid = 1'b0;
        idle(5);

        // CR handling
        send_byte(8'h68);
        send_byte(8'h0D);
        send_byte(8'h69);
        src_valid = 1'b0;
        idle(6);

        // Random traffic with occasional resets and frequent CRs
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            src_valid = 1'($urandom_range(0, 1));
            src_data  = ($urandom_range(0, 3) == 0) ? 8'h0D : 8'($urandom);
            snk_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        src_valid = 1'b0;
        snk_ready = 1'b1;
        idle(2 * DEPTH + 20);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial2tcp_loopback.md
SERIAL2TCP_LOOPBACK -- requirements
Module: serial2tcp_loopback

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, minimum 2.
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-004 serial2tcp_source_valid  input  1  incoming byte (TCP to gateware) valid.
REQ-005 serial2tcp_source_ready  output  1  block accepts incoming byte.
REQ-006 serial2tcp_source_data  input  8  incoming byte.
REQ-007 serial2tcp_sink_valid  output  1  outgoing byte (gateware to TCP) valid.
REQ-008 serial2tcp_sink_ready  input  1  consumer accepts outgoing byte.
REQ-009 serial2tcp_sink_data  output  8  outgoing byte.

Function
REQ-010 Block SHALL echo every accepted source byte on sink, in order, with no loss or duplication, via an internal DEPTH-entry FIFO.
REQ-011 Push SHALL occur on a rising edge where source_valid && source_ready; pop SHALL occur on a rising edge where sink_valid && sink_ready.
REQ-012 source_ready SHALL be 1 exactly when out of reset (see REQ-020) and FIFO occupancy < DEPTH; it SHALL NOT depend combinationally on sink_ready.
REQ-013 When FIFO is full, no push SHALL occur, even if a pop occurs in the same cycle.
REQ-014 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-015 FIFO SHALL be first-word-fall-through: a byte pushed into an empty FIFO at edge N SHALL appear on sink_data with sink_valid=1 immediately after edge N (1-cycle latency).
REQ-016 sink_valid SHALL be 1 exactly when a byte is available; sink_data SHALL hold stable while sink_valid && !sink_ready.
REQ-017 sink_data SHALL be 0x00 when sink_valid=0.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-019 source_data SHALL be ignored when source_valid=0; sink_ready SHALL be ignored when sink_valid=0.

Reset
REQ-020 While sys_rst_n=0 at an edge: pointers and occupancy cleared, source_ready=0, sink_valid=0, sink_data=0x00, LF-insert state (REQ-023) cleared. source_ready SHALL rise on the first edge sampling sys_rst_n=1.
REQ-021 Reset asserted mid-transfer SHALL discard all FIFO contents and any pending inserted byte; no stale byte SHALL appear after release.
REQ-022 FIFO storage array SHALL NOT require reset.

Configuration
REQ-023 With macro SERIAL2TCP_LOOPBACK_CRLF_EN defined: a two-state output FSM (PASS, INSERT_LF) SHALL follow each popped 0x0D with an inserted 0x0A; on pop of 0x0D in PASS go to INSERT_LF; in INSERT_LF sink_valid=1, sink_data=0x0A, FIFO not popped; on sink handshake return to PASS; inserted LF SHALL NOT occupy a FIFO entry; pushes continue during INSERT_LF.
REQ-024 Without SERIAL2TCP_LOOPBACK_CRLF_EN: every byte, including 0x0D, SHALL pass unmodified; no FSM logic present.

Verification
REQ-025 Reset held 3 cycles, release -> source_ready=0 during reset, 1 from first edge after release; sink_valid=0 throughout.
REQ-026 Push 0x41, 0x42, 0x43 with sink_ready=1 -> sink emits 0x41, 0x42, 0x43, each valid one cycle after its push.
REQ-027 sink_ready=0, push 16 bytes 0x00..0x0F (DEPTH=16) -> source_ready=0 after 16th push; 17th offer not accepted; then sink_ready=1 drains 0x00..0x0F in order, source_ready returns to 1 after first pop.
REQ-028 Continuous valid on both sides with sink_ready toggling every cycle over 256 bytes 0x00..0xFF -> sink output identical sequence, sink_data stable during stalls, pointers wrap correctly.
REQ-029 Reset asserted with 5 bytes queued -> after release sink_valid=0 and next pushed byte 0x55 is first byte out.
REQ-030 With SERIAL2TCP_LOOPBACK_CRLF_EN, push 0x68, 0x0D, 0x69 -> sink emits 0x68, 0x0D, 0x0A, 0x69; without macro -> 0x68, 0x0D, 0x69.
